// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 CUT: LFSR pattern source, MISR response compactor, golden compare.
// Optional C17_BIST_ALLZERO_EN prepends a single all-zero pattern before the LFSR sequence.
module c17_bist_ctrl #(
    parameter int          NUM_PATTERNS = 31,
    parameter logic [4:0]  LFSR_SEED    = 5'b00001,
    parameter logic [4:0]  GOLDEN_SIG   = 5'b00000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] pat_out,
    input  logic [1:0] resp_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(NUM_PATTERNS - 1);

    state_t     state_q, state_d;
    logic [4:0] lfsr_q, lfsr_d;
    logic [4:0] misr_q, misr_d;
    logic [4:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
`ifdef C17_BIST_ALLZERO_EN
    logic       zero_q, zero_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= 5'd0;
            misr_q  <= 5'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef C17_BIST_ALLZERO_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef C17_BIST_ALLZERO_EN
            zero_q  <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef C17_BIST_ALLZERO_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d  = LFSR_SEED;
                    misr_d  = 5'd0;
                    cnt_d   = 5'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
`ifdef C17_BIST_ALLZERO_EN
                    zero_d  = 1'b1;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                misr_d = {misr_q[3:0], misr_q[4] ^ misr_q[2]} ^ {3'b000, resp_in};
`ifdef C17_BIST_ALLZERO_EN
                // The all-zero cycle neither steps the LFSR nor counts as an LFSR pattern.
                if (zero_q) begin
                    zero_d = 1'b0;
                end else begin
`endif
                    lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_COMPARE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
`ifdef C17_BIST_ALLZERO_EN
                end
`endif
            end
            S_COMPARE: begin
                pass_d  = (misr_q == GOLDEN_SIG);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pat_out = 5'd0;
        if (state_q == S_RUN) begin
`ifdef C17_BIST_ALLZERO_EN
            pat_out = zero_q ? 5'd0 : lfsr_q;
`else
            pat_out = lfsr_q;
`endif
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_COMPARE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: drives the CUT response from a c17 model fed by the expected
// pattern list, with random and single-bit-error variants, and checks every RUN cycle.
module tb_c17_bist_ctrl;

    localparam int         NUM  = 31;
    localparam logic [4:0] SEED = 5'b00001;
`ifdef C17_BIST_ALLZERO_EN
    localparam int         LEN  = NUM + 1;
`else
    localparam int         LEN  = NUM;
`endif

    function automatic logic [1:0] c17(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [4:0] misr_step(input logic [4:0] m, input logic [1:0] r);
        return {m[3:0], m[4] ^ m[2]} ^ {3'b000, r};
    endfunction

    // Pattern k of a run: optional leading zero, then SEED advanced by x^5+x^3+1.
    function automatic logic [4:0] pattern(input int k);
        logic [4:0] l;
        int n;
        l = SEED;
        n = k;
`ifdef C17_BIST_ALLZERO_EN
        if (k == 0) return 5'd0;
        n = k - 1;
`endif
        for (int i = 0; i < n; i++) l = {l[3:0], l[4] ^ l[2]};
        return l;
    endfunction

    function automatic logic [4:0] golden_sig();
        logic [4:0] m;
        m = 5'd0;
        for (int k = 0; k < LEN; k++) m = misr_step(m, c17(pattern(k)));
        return m;
    endfunction

    localparam logic [4:0] GOLD = golden_sig();

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] pat_out;
    logic [1:0] resp_in = 2'b00;
    logic       busy, done, pass;
    logic [4:0] signature;

    int tests = 0;
    int fails = 0;

    c17_bist_ctrl #(
        .NUM_PATTERNS(NUM),
        .LFSR_SEED   (SEED),
        .GOLDEN_SIG  (GOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pat_out  (pat_out),
        .resp_in  (resp_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_pat"},  32'(pat_out),   32'd0);
        check_eq({tag, "_busy"}, 32'(busy),      32'd0);
        check_eq({tag, "_done"}, 32'(done),      32'd0);
        check_eq({tag, "_pass"}, 32'(pass),      32'd0);
        check_eq({tag, "_sig"},  32'(signature), 32'd0);
    endtask

    // mode: 0 = c17, 1 = tied zero, 2 = random. flip_k flips resp_in[0] at that pattern.
    // pulse_k pulses start during RUN. hold keeps start high; skip_start continues a held run.
    task automatic run(input int mode, input int flip_k, input int pulse_k,
                       input bit hold, input bit skip_start);
        logic [4:0] m;
        logic [1:0] r;
        m = 5'd0;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
        end
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            if (!hold) start = (k == pulse_k);
            check_eq("run_pat",  32'(pat_out), 32'(pattern(k)));
            check_eq("run_busy", 32'(busy), 32'd1);
            check_eq("run_done", 32'(done), 32'd0);
            check_eq("run_sig",  32'(signature), 32'(m));
            case (mode)
                0:       r = c17(pattern(k));
                1:       r = 2'b00;
                default: r = 2'($urandom_range(3));
            endcase
            if (k == flip_k) r[0] = ~r[0];
            resp_in = r;
            m = misr_step(m, r);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_eq("cmp_busy", 32'(busy), 32'd1);
        check_eq("cmp_pat",  32'(pat_out), 32'd0);
        check_eq("cmp_done", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("done_flag", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_sig",  32'(signature), 32'(m));
        check_eq("done_pass", 32'(pass), 32'(m == GOLD));
        if (mode == 0 && flip_k < 0) check_eq("golden_pass", 32'(pass), 32'd1);
        if (mode == 0 && flip_k >= 0) check_eq("flip_fail", 32'(pass), 32'd0);
    endtask

    task automatic check_done_held(input logic [4:0] sig, input logic exp_pass);
        repeat (3) begin
            @(negedge clk);
            check_eq("hold_done", 32'(done), 32'd1);
            check_eq("hold_pass", 32'(pass), 32'(exp_pass));
            check_eq("hold_sig",  32'(signature), 32'(sig));
        end
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // Real c17, fault free, then zero response held in DONE.
        run(0, -1, -1, 1'b0, 1'b0);
        check_done_held(signature, pass);
        run(1, -1, -1, 1'b0, 1'b0);
        check_eq("zero_sig", 32'(signature), 32'd0);
        check_done_held(5'd0, GOLD == 5'd0);

        // Single-cycle errors on the real CUT must never alias.
        for (int i = 0; i < 6; i++) run(0, int'($urandom_range(LEN - 1)), -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run(2, -1, -1, 1'b0, 1'b0);

        // Start pulses inside RUN are ignored.
        for (int i = 0; i < 3; i++) run(0, -1, int'($urandom_range(LEN - 1)), 1'b0, 1'b0);

        // Asynchronous reset mid-run, then a full-length rerun.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");
        run(0, -1, -1, 1'b0, 1'b0);

        // start held high: back-to-back runs, done high for one cycle each.
        run(0, -1, -1, 1'b1, 1'b0);
        run(2, -1, -1, 1'b1, 1'b1);
        run(0, -1, -1, 1'b1, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check_eq("released_done", 32'(done), 32'd1);
        check_eq("released_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
